// File: rtl/psum_collector_if.sv
// Serial psum stream from the collector toward the GLB/psum router.
// The collector drives data/valid/last; the consumer drives ready.
interface psum_collector_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/psum_collector.sv
// Gathers NUM_ITER column-reordered psum vectors from a PE cluster, then
// streams all X_dim*NUM_ITER psums out serially on a valid/ready port.
module psum_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int X_dim      = 5,
    parameter int NUM_ITER   = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         pe_out [X_dim-1:0],
    input  logic                          compute_done,
    psum_collector_if.master              stream,
    output logic [$clog2(NUM_ITER+1)-1:0] iter_count,
    output logic                          overflow
);
    localparam int DEPTH = X_dim * NUM_ITER;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = $clog2(NUM_ITER + 1);

    localparam logic [IW-1:0] LAST_ITER = IW'(NUM_ITER - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] STRIDE    = PW'(X_dim);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t                state;
    logic                  done_q;
    logic                  cap;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_next;
    logic [PW-1:0]         wr_base;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign cap     = compute_done & ~done_q;
    assign rd_next = rd_ptr + 1'b1;

    // Column 1 (highest pe_out index) lands first within each pass slot.
    always_ff @(posedge clk) begin
        if (reset && state == COLLECT && cap) begin
            for (int i = 0; i < X_dim; i++) begin
                mem[wr_base + PW'(i)] <= pe_out[X_dim-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= COLLECT;
            done_q           <= 1'b0;
            iter_count       <= '0;
            rd_ptr           <= '0;
            wr_base          <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            stream.out_data  <= '0;
            overflow         <= 1'b0;
        end else begin
            done_q <= compute_done;
            case (state)
                COLLECT: begin
                    if (cap) begin
                        iter_count <= iter_count + 1'b1;
                        if (iter_count == LAST_ITER) begin
                            state            <= DRAIN;
                            rd_ptr           <= '0;
                            wr_base          <= '0;
                            stream.out_valid <= 1'b1;
                            stream.out_last  <= (DEPTH == 1);
                            // With a single pass, slot 0 is being written on this very edge.
                            stream.out_data  <= (NUM_ITER == 1) ? pe_out[X_dim-1] : mem[0];
                        end else begin
                            wr_base <= wr_base + STRIDE;
                        end
                    end
                end
                DRAIN: begin
                    if (cap) begin
                        overflow <= 1'b1;
                    end
                    if (stream.out_ready) begin
                        if (stream.out_last) begin
                            state            <= COLLECT;
                            iter_count       <= '0;
                            rd_ptr           <= '0;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                        end else begin
                            rd_ptr          <= rd_next;
                            stream.out_data <= mem[rd_next];
                            stream.out_last <= (rd_next == LAST_PTR);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psum_collector.sv
// Directed and randomized bench for psum_collector, checked against a
// queue-based model of pass capture, reordering, draining and overflow.
module tb_psum_collector;
    localparam int DW       = 16;
    localparam int X_DIM    = 5;
    localparam int NITER    = 5;
    localparam int DEPTH    = X_DIM * NITER;
    localparam int IW       = $clog2(NITER + 1);

    logic          clk;
    logic          reset;
    logic          compute_done;
    logic [DW-1:0] pe_out [X_DIM-1:0];
    logic [IW-1:0] iter_count;
    logic          overflow;

    psum_collector_if #(.DATA_WIDTH(DW)) sif ();

    psum_collector #(
        .DATA_WIDTH(DW),
        .X_dim     (X_DIM),
        .NUM_ITER  (NITER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pe_out      (pe_out),
        .compute_done(compute_done),
        .stream      (sif.master),
        .iter_count  (iter_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int asserts_run = 0;
    int failures    = 0;
    int cyc         = 0;
    int hs_count    = 0;
    logic [DW-1:0] got_q [$];

    // Reference model: passes accumulate as whole vectors, then drain as a queue.
    int            m_passes   = 0;
    bit            m_draining = 0;
    bit            m_ovf      = 0;
    logic          m_done_q   = 1'b0;
    logic [DW-1:0] m_collect [$];
    logic [DW-1:0] m_stream  [$];

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        asserts_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_step(input logic cd, input logic rdy, input logic rst_n);
        logic cap;
        if (!rst_n) begin
            m_passes   = 0;
            m_draining = 0;
            m_ovf      = 0;
            m_done_q   = 1'b0;
            m_collect  = {};
            m_stream   = {};
        end else begin
            cap = cd && !m_done_q;
            if (m_draining) begin
                if (cap) m_ovf = 1;
                if (rdy) begin
                    void'(m_stream.pop_front());
                    if (m_stream.size() == 0) begin
                        m_draining = 0;
                        m_passes   = 0;
                    end
                end
            end else if (cap) begin
                for (int i = 0; i < X_DIM; i++) m_collect.push_back(pe_out[X_DIM-1-i]);
                m_passes++;
                if (m_passes == NITER) begin
                    m_stream   = m_collect;
                    m_collect  = {};
                    m_draining = 1;
                end
            end
            m_done_q = cd;
        end
    endtask

    task automatic checkOutput();
        check_value("out_valid", 32'(sif.out_valid), 32'(m_draining));
        if (m_draining) begin
            check_value("out_data", 32'(sif.out_data), 32'(m_stream[0]));
            check_value("out_last", 32'(sif.out_last), 32'(m_stream.size() == 1));
        end else begin
            check_value("out_last_idle", 32'(sif.out_last), 32'd0);
        end
        check_value("iter_count", 32'(iter_count), 32'(m_passes));
        check_value("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic applyStimulus(input logic cd, input logic rdy, input logic rst_n);
        reset         = rst_n;
        compute_done  = cd;
        sif.out_ready = rdy;
        if (rst_n && sif.out_valid === 1'b1 && rdy) begin
            got_q.push_back(sif.out_data);
            hs_count++;
        end
        model_step(cd, rdy, rst_n);
        cyc++;
        @(negedge clk);
        checkOutput();
    endtask

    function automatic logic ready_for(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_passes(input int hold, input int gap, input int rmode, input bit rand_data,
                              input bit inject, input int max_xfers);
        logic [DW-1:0] first0;
        logic          rdy;
        logic          cd;
        int            hs_start;
        int            n;
        first0   = '0;
        hs_start = hs_count;
        got_q    = {};
        for (int k = 0; k < NITER; k++) begin
            for (int i = 0; i < X_DIM; i++) begin
                pe_out[X_DIM-1-i] = rand_data ? DW'($urandom) : DW'(10 * k + i);
            end
            if (k == 0) first0 = pe_out[X_DIM-1];
            for (int h = 0; h < hold; h++) begin
                applyStimulus(1'b1, ready_for(rmode), 1'b1);
                if (k == NITER - 1 && h == 0) begin
                    check_value("final_cap_valid", 32'(sif.out_valid), 32'd1);
                    check_value("final_cap_data", 32'(sif.out_data), 32'(first0));
                end
            end
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, ready_for(rmode), 1'b1);
        end
        n = 0;
        while (m_draining && (hs_count - hs_start) < max_xfers && n < 500) begin
            rdy = ready_for(rmode);
            cd  = 1'b0;
            if (inject && (n == 3 || (m_stream.size() == 1 && rdy))) begin
                for (int i = 0; i < X_DIM; i++) pe_out[i] = 16'hDEAD;
                cd = 1'b1;
            end
            applyStimulus(cd, rdy, 1'b1);
            n++;
        end
        if (n >= 500) begin
            asserts_run++;
            failures++;
            $error("[TB] FAIL drain_timeout: observed=%0d cycles expected<500", n);
        end
        if (max_xfers == DEPTH) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_t1_stream(input string tag);
        check_value({tag, "_count"}, 32'(got_q.size()), 32'(DEPTH));
        for (int j = 0; j < got_q.size(); j++) begin
            check_value({tag, "_seq"}, 32'(got_q[j]), 32'(10 * (j / X_DIM) + (j % X_DIM)));
        end
    endtask

    initial begin
        reset         = 1'b0;
        compute_done  = 1'b0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < X_DIM; i++) pe_out[i] = '0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_value("reset_data", 32'(sif.out_data), 32'd0);

        $display("[TB] T1 basic");
        run_passes(1, 2, 0, 0, 0, DEPTH);
        check_t1_stream("t1");

        $display("[TB] T2 level compute_done");
        run_passes(7, 2, 0, 0, 0, DEPTH);
        check_t1_stream("t2");

        $display("[TB] T3 backpressure");
        run_passes(1, 1, 1, 1, 0, DEPTH);
        check_value("t3_handshakes", 32'(got_q.size()), 32'(DEPTH));

        $display("[TB] T4 overflow");
        run_passes(1, 2, 0, 0, 1, DEPTH);
        check_t1_stream("t4");
        check_value("t4_overflow", 32'(overflow), 32'd1);

        $display("[TB] T5 reset mid-drain");
        run_passes(1, 2, 0, 0, 0, 7);
        check_value("t5_partial", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < X_DIM; i++) pe_out[X_DIM-1-i] = DW'(i);
        applyStimulus(1'b1, 1'b1, 1'b0);
        check_value("t5_valid", 32'(sif.out_valid), 32'd0);
        check_value("t5_iter", 32'(iter_count), 32'd0);
        check_value("t5_ovf", 32'(overflow), 32'd0);
        run_passes(3, 2, 0, 0, 0, DEPTH);
        check_t1_stream("t5");

        $display("[TB] T7 random");
        for (int r = 0; r < 3; r++) begin
            run_passes(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 2, 1, 0, DEPTH);
            check_value("t7_handshakes", 32'(got_q.size()), 32'(DEPTH));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_run, failures);
        $finish;
    end
endmodule
